inst_buffer: RTL
================

INST_BUFFER -- requirements
Module: inst_buffer

Interface
REQ-001 The module SHALL have parameter N, default 3, meaning superscalar width (instructions per fetch and dispatch bundle).
REQ-002 The module SHALL have parameter DEPTH, default 16, meaning buffer entries; it is a power of two and at least 2*N.
REQ-003 Derived widths SHALL be SB = $clog2(N+1) for lane counts, PB = $clog2(DEPTH) for pointers, CB = $clog2(DEPTH+1) for occupancy.
REQ-004 The module SHALL have one clock; reset is synchronous and active-high.
REQ-005 Port: clock  in  1  rising-edge clock.
REQ-006 Port: reset  in  1  synchronous active-high reset.
REQ-007 Port: fetch_insts  in  N*32  fetched instruction words, lane 0 oldest.
REQ-008 Port: fetch_pcs  in  N*32  PCs matching fetch_insts.
REQ-009 Port: num_fetched  in  SB  valid fetch lanes, contiguous from lane 0.
REQ-010 Port: flush  in  1  mispredict/restore squash.
REQ-011 Port: num_dispatched  in  SB  instructions consumed by dispatch this cycle.
REQ-012 Port: instruction_packets  out  N*(32+32)  oldest min(count,N) entries {inst,pc}, lane 0 = head.
REQ-013 Port: instructions_valid  out  SB  min(count, N).
REQ-014 Port: ibuff_spots  out  CB  free entries, DEPTH - count.

Function
REQ-015 Storage SHALL be a circular array of DEPTH {inst,pc} entries with head, tail (PB bits, modulo DEPTH) and count (CB bits).
REQ-016 Outputs SHALL depend only on registered state: instruction_packets lane i = entry[(head+i) mod DEPTH]; lanes i >= instructions_valid SHALL read zero.
REQ-017 ibuff_spots and instructions_valid SHALL NOT depend combinationally on num_fetched, num_dispatched or flush.
REQ-018 Accepted enqueue count SHALL be enq = min(num_fetched, ibuff_spots); excess lanes SHALL be dropped; same-cycle dequeues do not create space.
REQ-019 Accepted dequeue count SHALL be deq = min(num_dispatched, instructions_valid).
REQ-020 On a non-flush edge, lanes 0..enq-1 SHALL be written at (tail+i) mod DEPTH; tail += enq; head += deq; count += enq - deq.
REQ-021 Simultaneous enqueue and dequeue SHALL be supported in one cycle, including when count = DEPTH (deq only) and count = 0 (enq only).
REQ-022 Enqueue-to-visibility latency SHALL be one cycle; an empty buffer SHALL show instructions_valid = 0 in the same cycle as an enqueue.
REQ-023 Pointer wrap SHALL be seamless: an output bundle straddling DEPTH-1 -> 0 SHALL present entries in program order.
REQ-024 When flush = 1 the next state SHALL be head = tail = count = 0; same-cycle enqueue and dequeue SHALL be ignored.
REQ-025 Entry contents SHALL NOT need clearing on flush or reset; the zero masking in REQ-016 hides stale data.
REQ-026 The count invariant 0 <= count <= DEPTH SHALL hold every cycle; an overflow or underflow SHALL be impossible by construction.

Reset
REQ-027 When reset = 1 at a rising edge, head = tail = count = 0; from the following cycle instructions_valid = 0, ibuff_spots = DEPTH and instruction_packets = 0.
REQ-028 Reset SHALL take priority over flush, enqueue and dequeue, including reset asserted mid-stream with a full buffer.

Verification (N=3, DEPTH=8)
REQ-029 Scenario: reset, then enqueue 3 (PCs 0x0,0x4,0x8) with num_dispatched = 0 -> next cycle instructions_valid = 3, lanes show PCs 0x0/0x4/0x8, ibuff_spots = 5.
REQ-030 Scenario: fetch 3 per cycle for 3 cycles, no dispatch -> count = 8, 9th instruction dropped, ibuff_spots = 0; then dispatch 3 with fetch 3 -> count = 5 (no same-cycle credit).
REQ-031 Scenario: head = 6 with 5 valid entries -> lanes show entries 6, 7, 0 in order; dispatch 3 -> head = 1.
REQ-032 Scenario: count = 2, num_dispatched = 3 -> deq = 2, count = 0, instructions_valid = 0 next cycle.
REQ-033 Scenario: count = 6, flush with fetch 3 and dispatch 2 in the same cycle -> next cycle count = 0, ibuff_spots = 8, instruction_packets = 0.
REQ-034 Scenario: random fetch/dispatch/flush for 10k cycles against a scoreboard queue -> dispatched PC sequence and count match the model every cycle.

Source files
------------

// File: rtl/inst_buffer_if.sv
// Fetch/dispatch-side bundle of the instruction buffer.
//   fetch_insts / fetch_pcs   : N lanes of 32-bit words, lane 0 oldest
//   num_fetched               : valid fetch lanes, contiguous from lane 0
//   flush                     : squash everything buffered
//   num_dispatched            : instructions consumed by dispatch this cycle
//   instruction_packets       : N lanes of {inst,pc}, lane 0 = head, unused lanes zero
//   instructions_valid        : min(count, N)
//   ibuff_spots               : free entries
// master = fetch/dispatch side, slave = the buffer.
interface inst_buffer_if #(
    parameter int N     = 3,
    parameter int DEPTH = 16
);
    localparam int unsigned SB = $clog2(N + 1);
    localparam int unsigned CB = $clog2(DEPTH + 1);

    logic [N*32-1:0] fetch_insts;
    logic [N*32-1:0] fetch_pcs;
    logic [SB-1:0]   num_fetched;
    logic            flush;
    logic [SB-1:0]   num_dispatched;
    logic [N*64-1:0] instruction_packets;
    logic [SB-1:0]   instructions_valid;
    logic [CB-1:0]   ibuff_spots;

    modport master (
        output fetch_insts, fetch_pcs, num_fetched, flush, num_dispatched,
        input  instruction_packets, instructions_valid, ibuff_spots
    );

    modport slave (
        input  fetch_insts, fetch_pcs, num_fetched, flush, num_dispatched,
        output instruction_packets, instructions_valid, ibuff_spots
    );
endinterface

// File: rtl/inst_buffer.sv
// Circular instruction buffer between a superscalar fetch stage and dispatch.
// Accepts up to N instructions per cycle, presents the oldest min(count,N)
// entries every cycle, and squashes its contents on flush.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous active-high reset (priority over everything)
//   ibif  : inst_buffer_if.slave (fetch inputs, dispatch count, flush,
//           output bundle, valid count and free-slot count)
module inst_buffer #(
    parameter int N     = 3,
    parameter int DEPTH = 16
) (
    input  logic          clock,
    input  logic          reset,
    inst_buffer_if.slave  ibif
);
    localparam int unsigned SB = $clog2(N + 1);
    localparam int unsigned PB = $clog2(DEPTH);
    localparam int unsigned CB = $clog2(DEPTH + 1);

    logic [63:0]   r_mem [DEPTH];
    logic [PB-1:0] r_head;
    logic [PB-1:0] r_tail;
    logic [CB-1:0] r_count;

    logic [SB-1:0]   w_valid;
    logic [CB-1:0]   w_spots;
    logic [SB-1:0]   w_enq;
    logic [SB-1:0]   w_deq;
    logic [N*64-1:0] w_packets;

    // Status comes from registered count only; same-cycle dequeues never
    // create room for same-cycle enqueues.
    always_comb begin
        w_valid = (r_count >= CB'(N)) ? SB'(N) : r_count[SB-1:0];
        w_spots = CB'(DEPTH) - r_count;
        // When spots < num_fetched, spots is below N and fits in SB bits.
        w_enq   = (CB'(ibif.num_fetched) > w_spots) ? w_spots[SB-1:0] : ibif.num_fetched;
        w_deq   = (ibif.num_dispatched > w_valid) ? w_valid : ibif.num_dispatched;
    end

    // Lanes beyond the valid count read zero so stale entries never leak.
    always_comb begin
        w_packets = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (SB'(i) < w_valid)
                w_packets[i*64 +: 64] = r_mem[r_head + PB'(i)];
        end
    end

    assign ibif.instruction_packets = w_packets;
    assign ibif.instructions_valid  = w_valid;
    assign ibif.ibuff_spots         = w_spots;

    always_ff @(posedge clock) begin
        if (reset || ibif.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PB'(w_deq);
            r_tail  <= r_tail + PB'(w_enq);
            r_count <= r_count + CB'(w_enq) - CB'(w_deq);
        end
    end

    // Entry storage is never cleared; pointer arithmetic wraps modulo DEPTH.
    always_ff @(posedge clock) begin
        if (!reset && !ibif.flush) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (SB'(i) < w_enq)
                    r_mem[r_tail + PB'(i)] <= {ibif.fetch_insts[i*32 +: 32],
                                               ibif.fetch_pcs[i*32 +: 32]};
            end
        end
    end
endmodule
